inv_sub_bytes_seq: RTL
======================

// Module: inv_sub_bytes_seq
//
// PURPOSE
// - Sequential AES InvSubBytes engine: applies the inverse S-box to every byte of a
//   128-bit state, one 32-bit word per clock, through a shared inverse sub-word lookup.
// - Decryption-side counterpart of the forward sub_word stage; sits in the SIMD AES
//   decrypt datapath between InvShiftRows and AddRoundKey.
// - Valid/ready on both sides; holds the result until the consumer takes it.
//
// PARAMETERS
// - REG_SIZE   32  word width in bits; must be a multiple of 8
// - NUM_WORDS  4   words per state block; state width = REG_SIZE*NUM_WORDS
//
// PORTS
// - clk        in   1                   system clock, rising edge
// - rst        in   1                   asynchronous, active-high reset
// - in_valid   in   1                   state_in is valid
// - in_ready   out  1                   block can accept a new state
// - state_in   in   REG_SIZE*NUM_WORDS  input state; word i = bits [REG_SIZE*i +: REG_SIZE]
// - out_valid  out  1                   state_out holds a finished result
// - out_ready  in   1                   consumer accepts state_out
// - state_out  out  REG_SIZE*NUM_WORDS  inverse-substituted state, same word/byte layout
// - busy       out  1                   high in PROC or DONE
//
// BEHAVIOUR
// - One clock domain: clk. Reset is asynchronous and active-high: rst.
// - Reset (async assert): FSM=IDLE, word counter=0, state buffer=0, out_valid=0,
//   state_out=0, busy=0; in_ready=1 once in IDLE.
// - FSM states IDLE, PROC, DONE:
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch state_in into the buffer, cnt=0 -> PROC.
//   - PROC: in_ready=0. Each cycle buffer word[cnt] <= inv_sub_word(buffer word[cnt]);
//     cnt<=cnt+1. On the edge processing word NUM_WORDS-1 -> DONE (cnt back to 0).
//   - DONE: out_valid=1, state_out=buffer, in_ready=0. On out_valid&&out_ready -> IDLE.
// - Latency: accept at edge k; out_valid high after edge k+NUM_WORDS (4 cycles default).
// - Throughput: with in_valid and out_ready held high, one accept every NUM_WORDS+2 cycles;
//   no accept in the same cycle as an output handshake.
// - Backpressure: while out_ready=0 in DONE, out_valid and state_out hold stable.
// - in_valid outside IDLE is ignored; state_in need only be stable in the accept cycle.
// - Each byte maps independently: out_byte = INV_SBOX[in_byte]; no cross-byte carry.
// - Counter width $clog2(NUM_WORDS); never exceeds NUM_WORDS-1 (no wrap past range).
// - Reset mid-PROC or mid-DONE: in-flight block discarded, no out_valid produced.
// - state_out is registered and equals 0 whenever out_valid=0.
//
// STRUCTURE
// - Package aes_pkg: INV_SBOX constant (256 x 8-bit), byte_t typedef, FSM state enum
//   (IDLE/PROC/DONE).
// - Sub-module inv_sub_word #(REG_SIZE): combinational, word_in -> word_out through
//   INV_SBOX per byte; one instance, shared across all words via the counter mux.
// - Top: FSM, counter, state buffer, output register.
//
// TESTING
// - Reset: assert rst mid-cycle -> immediately out_valid=0, state_out=0, busy=0; in_ready=1.
// - Single block: state_in={7575d2d2,7676c0c0,7b7bc5c5,63637c7c} (word3..word0) ->
//   state_out={3f3f7f7f,0f0f1f1f,03030707,00000101}; out_valid exactly 4 cycles after accept.
// - Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and state_out unchanged,
//   in_ready=0, held in_valid not accepted; release -> IDLE next cycle.
// - Round trip: 64 blocks covering bytes 00..ff through sub_word then this block ->
//   every byte recovered; spot check 63->00, 7c->01, c5->07, d2->7f.
// - Reset mid-PROC after 2 words -> IDLE, out_valid never rises; next block correct.
// - Streaming: in_valid and out_ready held high -> accepts exactly every 6 cycles,
//   results in order, no dropped or duplicated blocks.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decrypt-side definitions: inverse S-box table, byte type and the
// sequencer state encoding used by the InvSubBytes engine.
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ascending outer range so the leftmost byte of each row literal is the lowest index.
  localparam byte_t [0:255] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

endpackage

// File: rtl/inv_sub_word.sv
// Combinational inverse substitution of one word; every byte goes through its
// own INV_SBOX lookup with no interaction between bytes.
module inv_sub_word
  import aes_pkg::*;
#(
  parameter int REG_SIZE = 32
) (
  input  logic [REG_SIZE-1:0] word_in,
  output logic [REG_SIZE-1:0] word_out
);

  for (genvar b = 0; b < REG_SIZE/8; b++) begin : g_byte
    assign word_out[8*b +: 8] = INV_SBOX[word_in[8*b +: 8]];
  end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: one word per clock through a single shared
// inv_sub_word lookup, result held in an output register until taken.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int REG_SIZE  = 32,
  parameter int NUM_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_SIZE*NUM_WORDS-1:0] state_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [REG_SIZE*NUM_WORDS-1:0] state_out,
  output logic                          busy
);

  localparam int SW = REG_SIZE*NUM_WORDS;
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS-1);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [NUM_WORDS-1:0][REG_SIZE-1:0] buf_q, buf_d;
  logic [SW-1:0]                      out_q, out_d;
  logic                               vld_q, vld_d;
  logic [REG_SIZE-1:0]                word_sub;

  inv_sub_word #(.REG_SIZE(REG_SIZE)) u_inv_sub_word (
    .word_in  (buf_q[cnt_q]),
    .word_out (word_sub)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    out_d   = out_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = state_in;
          cnt_d   = '0;
          state_d = PROC;
        end
      end
      PROC: begin
        buf_d[cnt_q] = word_sub;
        if (cnt_q == LAST) begin
          // Output register takes the fully substituted buffer including this word.
          cnt_d   = '0;
          out_d   = buf_d;
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_d   = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign state_out = out_q;

endmodule
